// File: rtl/dvp_camera_power_seq_if.sv
// Camera-side bundle: configuration word in, camera pins and readiness out.
interface dvp_camera_power_seq_if #(
    parameter int unsigned DVP_CAM_CFG_W = 8
);
    logic [DVP_CAM_CFG_W-1:0] dcr_cam_cfg_i;
    logic                     dvp_xclk_o;
    logic                     dvp_pwdn_o;
    logic                     dvp_rst_n_o;
    logic                     cam_ready_o;

    // Controller side: consumes the config word, drives the camera pins.
    modport master (
        input  dcr_cam_cfg_i,
        output dvp_xclk_o,
        output dvp_pwdn_o,
        output dvp_rst_n_o,
        output cam_ready_o
    );

    // Environment side: register block and camera/RX path.
    modport slave (
        output dcr_cam_cfg_i,
        input  dvp_xclk_o,
        input  dvp_pwdn_o,
        input  dvp_rst_n_o,
        input  cam_ready_o
    );
endinterface

// File: rtl/dvp_camera_power_seq.sv
// DVP camera power sequencer: timed power-up of PWDN/RESET pins, a
// prescaled XCLK generator, and a glitch-free power-down that always
// parks XCLK low before re-asserting power-down.
module dvp_camera_power_seq #(
    parameter int unsigned INTL_CLK_FREQ = 125000000,
    parameter int unsigned CAM_MAX_FREQ  = 24000000,
    parameter int unsigned DVP_CAM_CFG_W = 8,
    parameter int unsigned PWUP_DLY_CYC  = 125000,
    parameter int unsigned RST_DLY_CYC   = 2500000
) (
    input  logic                   clk,
    input  logic                   rst,
    dvp_camera_power_seq_if.master bus
);

    // A zero delay still spends one cycle in its state.
    localparam int unsigned PWUP_CYC  = (PWUP_DLY_CYC == 0) ? 1 : PWUP_DLY_CYC;
    localparam int unsigned RST_CYC   = (RST_DLY_CYC == 0) ? 1 : RST_DLY_CYC;
    localparam int unsigned DLY_MAX   = (PWUP_CYC > RST_CYC) ? PWUP_CYC : RST_CYC;
    localparam int unsigned DWELL_W   = $clog2(DLY_MAX) + 1;

    // Fastest XCLK half-period, rounded up so XCLK never exceeds CAM_MAX_FREQ.
    localparam int unsigned HALF_BASE = (INTL_CLK_FREQ + 2 * CAM_MAX_FREQ - 1)
                                        / (2 * CAM_MAX_FREQ);
    localparam int unsigned XCNT_W    = $clog2(HALF_BASE * 8 + 1);

    localparam int unsigned START_BIT = (DVP_CAM_CFG_W > 7) ? 7 : DVP_CAM_CFG_W - 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_PWUP,
        S_RST_REL,
        S_READY,
        S_SHDN
    } state_e;

    state_e              state_q,  state_d;
    logic [DWELL_W-1:0]  dwell_q,  dwell_d;
    logic                pwdn_q,   pwdn_d;
    logic                rst_n_q,  rst_n_d;
    logic                ready_q,  ready_d;

    logic                xclk_q,   xclk_d;
    logic [XCNT_W-1:0]   xcnt_q,   xcnt_d;
    logic [1:0]          presc_q,  presc_d;

    logic                cam_start_c;
    logic [1:0]          cam_presc_c;
    logic                xclk_en_c;
    logic                xclk_stopped_c;
    logic [XCNT_W-1:0]   half_c;

    assign cam_start_c = bus.dcr_cam_cfg_i[START_BIT];
    assign cam_presc_c = bus.dcr_cam_cfg_i[1:0];

    // XCLK runs in every powered state; SHDN drops the request.
    assign xclk_en_c = (state_q == S_PWUP) || (state_q == S_RST_REL) || (state_q == S_READY);

    // XCLK divider: presc only changes while stopped or at a falling toggle.
    always_comb begin
        xclk_d         = xclk_q;
        xcnt_d         = xcnt_q;
        presc_d        = presc_q;
        half_c         = XCNT_W'(HALF_BASE) << presc_q;
        xclk_stopped_c = !xclk_q && !xclk_en_c;

        if (xclk_stopped_c) begin
            xcnt_d  = '0;
            presc_d = cam_presc_c;
        end else if (xcnt_q == half_c - XCNT_W'(1)) begin
            xcnt_d = '0;
            xclk_d = !xclk_q;
            if (xclk_q) begin
                presc_d = cam_presc_c;
            end
        end else begin
            xcnt_d = xcnt_q + XCNT_W'(1);
        end
    end

    // Sequencer next state, shared dwell counter and pin values for the next state.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;

        case (state_q)
            S_OFF: begin
                if (cam_start_c) begin
                    state_d = S_PWUP;
                end
            end
            S_PWUP: begin
                if (!cam_start_c) begin
                    state_d = S_SHDN;
                end else if (dwell_q == DWELL_W'(PWUP_CYC - 1)) begin
                    state_d = S_RST_REL;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            S_RST_REL: begin
                if (!cam_start_c) begin
                    state_d = S_SHDN;
                end else if (dwell_q == DWELL_W'(RST_CYC - 1)) begin
                    state_d = S_READY;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            S_READY: begin
                if (!cam_start_c) begin
                    state_d = S_SHDN;
                end
            end
            S_SHDN: begin
                // Completes regardless of cam_start; restart is taken from OFF.
                if (xclk_stopped_c) begin
                    state_d = S_OFF;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        if (state_d != state_q) begin
            dwell_d = '0;
        end

        pwdn_d  = (state_d == S_OFF);
        rst_n_d = (state_d == S_RST_REL) || (state_d == S_READY);
        ready_d = (state_d == S_READY);
    end

    // All state and pin flops; reset returns to the powered-down pin state at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            dwell_q <= '0;
            pwdn_q  <= 1'b1;
            rst_n_q <= 1'b0;
            ready_q <= 1'b0;
            xclk_q  <= 1'b0;
            xcnt_q  <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            pwdn_q  <= pwdn_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            xclk_q  <= xclk_d;
            xcnt_q  <= xcnt_d;
            presc_q <= presc_d;
        end
    end

    assign bus.dvp_xclk_o  = xclk_q;
    assign bus.dvp_pwdn_o  = pwdn_q;
    assign bus.dvp_rst_n_o = rst_n_q;
    assign bus.cam_ready_o = ready_q;

endmodule
